// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered-read block-RAM storage, exact occupancy count,
// level/threshold flags, sticky overflow/underflow and synchronous flush.
// Read data appears one edge after an accepted read; full/empty refuse requests and set sticky errors.
module sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  // Thresholds sized to the level register so the flag compares are width-exact.
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = LW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = LW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  wa;
  logic                  ra;

  // Flags decode only the registered level, so they move one edge after a request.
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_LVL);
  assign almost_full  = (level >= AFULL_LVL);
  assign almost_empty = (level <= AEMPTY_LVL);

  // A flush blocks both ports; full refuses writes and empty refuses reads, even
  // when the opposite port is active in the same cycle (no write-through / fall-through).
  assign wa = we & ~full & ~clr;
  assign ra = re & ~empty & ~clr;

  // Storage write port; contents are deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wa) mem[waddr] <= d;
  end

  // Pointers wrap naturally at DEPTH; level tracks exact occupancy so all entries are usable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
    end else if (clr) begin
      waddr <= '0;
      raddr <= '0;
      level <= '0;
    end else begin
      if (wa) waddr <= waddr + 1'b1;
      if (ra) raddr <= raddr + 1'b1;
      if (wa && !ra)      level <= level + 1'b1;
      else if (ra && !wa) level <= level - 1'b1;
    end
  end

  // Registered read port; q holds between reads and is left untouched by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else begin
      q_valid <= ra;
      if (ra) q <= mem[raddr];
    end
  end

  // Sticky error flags: a refused request sets them, only reset or flush clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && full)  overflow  <= 1'b1;
      if (re && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a 16-deep byte FIFO against a queue-based reference model,
// plus three 2048-deep instances of different widths driven in parallel.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic we  = 1'b0;
  logic re  = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       q_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;

  logic        sw_clr = 1'b0;
  logic        sw_we  = 1'b0;
  logic        sw_re  = 1'b0;
  logic [31:0] sw_d   = 32'h0;
  logic [0:0]  w1_q;
  logic [16:0] w17_q;
  logic [31:0] w32_q;
  logic [11:0] w1_level, w17_level, w32_level;
  logic w1_qv, w1_empty, w1_full, w1_ae, w1_af, w1_ovf, w1_udf;
  logic w17_qv, w17_empty, w17_full, w17_ae, w17_af, w17_ovf, w17_udf;
  logic w32_qv, w32_empty, w32_full, w32_ae, w32_af, w32_ovf, w32_udf;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus the observable registered outputs.
  logic [7:0] mq[$];
  logic [7:0] m_q;
  logic       m_qv, m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .d(d), .re(re),
    .q(q), .q_valid(q_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(11), .AEMPTY_LEVEL(0)) u_w1 (
    .clk(clk), .rst(rst), .clr(sw_clr), .we(sw_we), .d(sw_d[0:0]), .re(sw_re),
    .q(w1_q), .q_valid(w1_qv), .empty(w1_empty), .full(w1_full),
    .almost_empty(w1_ae), .almost_full(w1_af),
    .level(w1_level), .overflow(w1_ovf), .underflow(w1_udf)
  );

  sync_fifo #(.DATA_WIDTH(17), .ADDR_WIDTH(11), .AEMPTY_LEVEL(0)) u_w17 (
    .clk(clk), .rst(rst), .clr(sw_clr), .we(sw_we), .d(sw_d[16:0]), .re(sw_re),
    .q(w17_q), .q_valid(w17_qv), .empty(w17_empty), .full(w17_full),
    .almost_empty(w17_ae), .almost_full(w17_af),
    .level(w17_level), .overflow(w17_ovf), .underflow(w17_udf)
  );

  sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .AEMPTY_LEVEL(0)) u_w32 (
    .clk(clk), .rst(rst), .clr(sw_clr), .we(sw_we), .d(sw_d), .re(sw_re),
    .q(w32_q), .q_valid(w32_qv), .empty(w32_empty), .full(w32_full),
    .almost_empty(w32_ae), .almost_full(w32_af),
    .level(w32_level), .overflow(w32_ovf), .underflow(w32_udf)
  );

  task automatic model_reset;
    mq.delete();
    m_q   = 8'h00;
    m_qv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // One clock of stimulus on the 16-deep FIFO; called at a falling edge, returns at the next one.
  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] dv);
    int sz;
    bit fl, em;
    we = w; re = r; clr = c; d = dv;
    sz = mq.size();
    fl = (sz == 16);
    em = (sz == 0);
    @(posedge clk);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_qv  = 1'b0;
    end else begin
      if (w && fl) m_ovf = 1'b1;
      if (r && em) m_udf = 1'b1;
      m_qv = r && !em;
      if (r && !em) m_q = mq.pop_front();
      if (w && !fl) mq.push_back(dv);
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic sw_drive(input logic w, input logic r, input logic [31:0] dv);
    sw_we = w; sw_re = r; sw_d = dv;
    @(posedge clk);
    @(negedge clk);
    sw_we = 1'b0; sw_re = 1'b0;
  endtask

  task automatic test_reset;
    logic [19:0] got;
    @(negedge clk);
    got = {level, empty, almost_empty, almost_full, full, q_valid, overflow, underflow, q};
    checks++;
    if (got !== {5'd0, 7'b1100000, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", got, {5'd0, 7'b1100000, 8'h00});
    end
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({underflow, q_valid, level} !== {1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL read_on_empty: udf/qv/level %b/%b/%0d required 1/0/0", underflow, q_valid, level);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({q_valid, level, q} !== {1'b1, 5'd5, m_q}) begin
      errors++;
      $display("FAIL pre_reset_read: qv/level/q %b/%0d/%h required 1/5/%h", q_valid, level, q, m_q);
    end
    // Asynchronous reset mid-cycle, checked before the next rising edge.
    #2 rst = 1'b1;
    #1;
    got = {level, empty, almost_empty, almost_full, full, q_valid, overflow, underflow, q};
    checks++;
    if (got !== {5'd0, 7'b1100000, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", got, {5'd0, 7'b1100000, 8'h00});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({underflow, q_valid, level, empty} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_read: udf/qv/level/empty %b/%b/%0d/%b required 1/0/0/1",
               underflow, q_valid, level, empty);
    end
  endtask

  task automatic test_fill_drain;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_sticky: underflow %b required 0", underflow);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i));
      checks++;
      if ({level, full, almost_full, almost_empty} !== {5'(i + 1), (i == 15), (i + 1 >= 12), (i + 1 <= 4)}) begin
        errors++;
        $display("FAIL fill_%0d: level/full/af/ae %0d/%b/%b/%b required %0d/%b/%b/%b", i, level, full,
                 almost_full, almost_empty, i + 1, (i == 15), (i + 1 >= 12), (i + 1 <= 4));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'hAA);
    checks++;
    if ({overflow, level, full} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL overflow_write: ovf/level/full %b/%0d/%b required 1/16/1", overflow, level, full);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if ({q_valid, q} !== {1'b1, 8'(i)}) begin
        errors++;
        $display("FAIL drain_%0d: qv/q %b/%h required 1/%h", i, q_valid, q, 8'(i));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({q_valid, empty, q} !== {1'b0, 1'b1, 8'h0F}) begin
      errors++;
      $display("FAIL drain_idle: qv/empty/q %b/%b/%h required 0/1/0f", q_valid, empty, q);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'($urandom));
      checks++;
      if ({level, q_valid, q} !== {5'd3, 1'b1, m_q}) begin
        errors++;
        $display("FAIL wrap_%0d: level/qv/q %0d/%b/%h required 3/1/%h", i, level, q_valid, q, m_q);
      end
    end
  endtask

  task automatic test_boundaries;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0, 8'($urandom));
    checks++;
    if ({level, full, overflow, q_valid, q} !== {5'd15, 1'b0, 1'b1, 1'b1, m_q}) begin
      errors++;
      $display("FAIL full_rw: level/full/ovf/qv/q %0d/%b/%b/%b/%h required 15/0/1/1/%h",
               level, full, overflow, q_valid, q, m_q);
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if ({q_valid, q} !== {1'b1, m_q}) begin
        errors++;
        $display("FAIL bound_drain_%0d: qv/q %b/%h required 1/%h", i, q_valid, q, m_q);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 8'($urandom));
    checks++;
    if ({level, underflow, q_valid, overflow} !== {5'd1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL empty_rw: level/udf/qv/ovf %0d/%b/%b/%b required 1/1/0/1",
               level, underflow, q_valid, overflow);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({q_valid, q, empty} !== {1'b1, m_q, 1'b1}) begin
      errors++;
      $display("FAIL empty_rw_data: qv/q/empty %b/%h/%b required 1/%h/1", q_valid, q, empty, m_q);
    end
  endtask

  task automatic test_flush;
    logic [7:0] qprev;
    logic [7:0] v;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    qprev = m_q;
    checks++;
    if ({level, q_valid, underflow} !== {5'd9, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_flush: level/qv/udf %0d/%b/%b required 9/1/1", level, q_valid, underflow);
    end
    drive(1'b1, 1'b1, 1'b1, 8'($urandom));
    checks++;
    if ({level, empty, overflow, underflow, q_valid, q} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, qprev}) begin
      errors++;
      $display("FAIL flush: level/empty/ovf/udf/qv/q %0d/%b/%b/%b/%b/%h required 0/1/0/0/0/%h",
               level, empty, overflow, underflow, q_valid, q, qprev);
    end
    v = 8'($urandom);
    drive(1'b1, 1'b0, 1'b0, v);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({q_valid, q, level} !== {1'b1, v, 5'd0}) begin
      errors++;
      $display("FAIL post_flush: qv/q/level %b/%h/%0d required 1/%h/0", q_valid, q, level, v);
    end
  endtask

  task automatic test_random;
    logic [19:0] got, exp;
    logic [4:0]  esz;
    int pw, pr;
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0:       begin pw = 85; pr = 25; end
        1:       begin pw = 20; pr = 85; end
        2:       begin pw = 60; pr = 55; end
        default: begin pw = 50; pr = 50; end
      endcase
      drive(($urandom_range(99) < pw), ($urandom_range(99) < pr), ($urandom_range(99) < 2), 8'($urandom));
      esz = 5'(mq.size());
      exp = {esz, esz == 0, esz == 16, esz <= 4, esz >= 12, m_qv, m_ovf, m_udf, m_q};
      got = {level, empty, full, almost_empty, almost_full, q_valid, overflow, underflow, q};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_sweep;
    logic [31:0] sq[$];
    logic [31:0] v;
    logic        ee;
    checks++;
    if ({w1_empty, w1_ae, w17_empty, w17_ae, w32_empty, w32_ae} !== 6'b111111) begin
      errors++;
      $display("FAIL sweep_idle: empty/ae %b%b %b%b %b%b required all 1",
               w1_empty, w1_ae, w17_empty, w17_ae, w32_empty, w32_ae);
    end
    for (int i = 0; i < 2048; i++) begin
      v = $urandom;
      sw_drive(1'b1, 1'b0, v);
      sq.push_back(v);
      if (i == 0) begin
        checks++;
        if ({w1_empty, w1_ae, w17_empty, w17_ae, w32_empty, w32_ae} !== 6'b000000) begin
          errors++;
          $display("FAIL sweep_first: empty/ae %b%b %b%b %b%b required all 0",
                   w1_empty, w1_ae, w17_empty, w17_ae, w32_empty, w32_ae);
        end
      end
    end
    checks++;
    if ({w1_full, w17_full, w32_full, w1_af, w17_af, w32_af, w1_level, w17_level, w32_level} !==
        {6'b111111, 12'd2048, 12'd2048, 12'd2048}) begin
      errors++;
      $display("FAIL sweep_full: full %b%b%b af %b%b%b level %0d/%0d/%0d required 111 111 2048",
               w1_full, w17_full, w32_full, w1_af, w17_af, w32_af, w1_level, w17_level, w32_level);
    end
    sw_drive(1'b1, 1'b0, $urandom);
    checks++;
    if ({w1_ovf, w17_ovf, w32_ovf, w32_level} !== {3'b111, 12'd2048}) begin
      errors++;
      $display("FAIL sweep_ovf: ovf %b%b%b level %0d required 111/2048", w1_ovf, w17_ovf, w32_ovf, w32_level);
    end
    for (int i = 0; i < 2048; i++) begin
      sw_drive(1'b0, 1'b1, 32'h0);
      v  = sq.pop_front();
      ee = (i == 2047);
      checks++;
      if ({w1_q, w17_q, w32_q, w1_qv, w17_qv, w32_qv, w1_ae, w1_empty, w17_ae, w17_empty, w32_ae, w32_empty} !==
          {v[0], v[16:0], v, 3'b111, ee, ee, ee, ee, ee, ee}) begin
        errors++;
        $display("FAIL sweep_read_%0d: q %h/%h/%h qv %b%b%b ae/empty %b%b %b%b %b%b required q %h/%h/%h qv 111 all %b",
                 i, w1_q, w17_q, w32_q, w1_qv, w17_qv, w32_qv, w1_ae, w1_empty, w17_ae, w17_empty,
                 w32_ae, w32_empty, v[0], v[16:0], v, ee);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_boundaries();
    test_flush();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
